// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage.
//   - default address / instruction widths (same as program_counter users)
//   - default prefetch depth
//   - fetch FSM state encoding
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int FETCH_AW    = 16;
    localparam int FETCH_DW    = 16;
    localparam int FETCH_DEPTH = 4;

    // IDLE : nothing outstanding, waiting for a free buffer slot
    // ADDR : PC output enabled, request address captured
    // REQ  : memory read outstanding
    // DRAIN: request outstanding but its data is discarded after a flush
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bus bundle of the fetch stage: the instruction-memory read handshake and
// the decoder-facing instruction stream.
//   o_mem_req/o_mem_addr   read request, held until acknowledged
//   i_mem_ack/i_mem_data   one-cycle ack with data in the same cycle
//   o_instr_valid/o_instr/o_instr_addr  head of the prefetch buffer
//   i_instr_ready          decoder accepts the head word
// Modports: master = fetch stage, slave = memory + decoder side.
// ---------------------------------------------------------------------------
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int AW = FETCH_AW,
    parameter int DW = FETCH_DW
);

    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_data;

    logic          o_instr_valid;
    logic [DW-1:0] o_instr;
    logic [AW-1:0] o_instr_addr;
    logic          i_instr_ready;

    modport master (
        output o_mem_req,
        output o_mem_addr,
        input  i_mem_ack,
        input  i_mem_data,
        output o_instr_valid,
        output o_instr,
        output o_instr_addr,
        input  i_instr_ready
    );

    modport slave (
        input  o_mem_req,
        input  o_mem_addr,
        output i_mem_ack,
        output i_mem_data,
        input  o_instr_valid,
        input  o_instr,
        input  o_instr_addr,
        output i_instr_ready
    );

endinterface

// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer (fetch_buffer)
// Synchronous FIFO holding {address, instruction} pairs for the fetch stage.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push/wdata write one entry (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   clear      empty the buffer; overrides push and pop
//   rdata      head entry
//   count      number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module instr_fetch_buffer
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int WIDTH = FETCH_AW + FETCH_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow so the count can never leave 0..DEPTH.
    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);

    assign rdata = mem[rd_ptr];

    // Pointer/count/storage update. Storage is zeroed on reset so the head
    // reads as zero until the first word arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage sitting directly after program_counter. It gates the PC with
// lock / address-enable / set, reads one 16-bit word at a time from
// instruction memory, buffers {address, word} pairs and hands them to the
// decoder over valid/ready. A decoder flush redirects the PC and empties
// the buffer.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   i_pc_address       PC value (meaningful while o_pc_addr_en=1)
//   o_pc_addr_en       PC address enable
//   o_pc_lock          PC hold; released for exactly one cycle per word
//   o_pc_set_en        PC load (driven by flush)
//   o_pc_set_address   PC load target
//   bus                memory read handshake + decoder stream (master side)
//   i_flush            one-cycle redirect request
//   i_flush_addr       redirect target
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int AW    = FETCH_AW,
    parameter int DW    = FETCH_DW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  i_pc_address,
    output logic           o_pc_addr_en,
    output logic           o_pc_lock,
    output logic           o_pc_set_en,
    output logic [AW-1:0]  o_pc_set_address,
    instr_fetch_if.master  bus,
    input  logic           i_flush,
    input  logic [AW-1:0]  i_flush_addr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic [AW-1:0]  req_addr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_after_pop;
    logic           push;
    logic           pop;
    logic [AW+DW-1:0] head;

    // The flush cycle hides the head so the decoder never consumes a word
    // that is about to be thrown away.
    assign bus.o_instr_valid = (count != '0) && !i_flush;
    assign pop               = bus.o_instr_valid && bus.i_instr_ready;
    assign count_after_pop   = count - CW'(pop);
    assign {bus.o_instr_addr, bus.o_instr} = head;

    // Redirect goes straight to the PC; the PC gives set priority over lock.
    assign o_pc_set_en      = i_flush;
    assign o_pc_set_address = i_flush ? i_flush_addr : '0;

    instr_fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (AW + DW)
    ) u_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (i_flush),
        .wdata ({req_addr, bus.i_mem_data}),
        .rdata (head),
        .count (count)
    );

    // State register plus the captured request address. The address is
    // captured on every ADDR cycle, so a flush that keeps us in ADDR simply
    // recaptures the redirected PC on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ADDR) begin
                req_addr <= i_pc_address;
            end
        end
    end

    // Next state and PC/memory controls. Only one request is ever
    // outstanding, and ADDR is only entered with a free slot, so the push
    // in REQ can never hit a full buffer. The PC is released only on an
    // accepted (pushed) ack, giving exactly one increment per word.
    always_comb begin
        state_nxt     = state;
        o_pc_addr_en  = 1'b0;
        o_pc_lock     = 1'b1;
        bus.o_mem_req  = 1'b0;
        bus.o_mem_addr = '0;
        push          = 1'b0;

        case (state)
            IDLE: begin
                if (i_flush || (count_after_pop < FULL)) begin
                    state_nxt = ADDR;
                end
            end

            ADDR: begin
                o_pc_addr_en = 1'b1;
                state_nxt    = i_flush ? ADDR : REQ;
            end

            REQ: begin
                bus.o_mem_req  = 1'b1;
                bus.o_mem_addr = req_addr;
                if (i_flush) begin
                    state_nxt = bus.i_mem_ack ? ADDR : DRAIN;
                end else if (bus.i_mem_ack) begin
                    push      = 1'b1;
                    o_pc_lock = 1'b0;
                    state_nxt = (count_after_pop < LAST) ? ADDR : IDLE;
                end
            end

            DRAIN: begin
                bus.o_mem_req  = 1'b1;
                bus.o_mem_addr = req_addr;
                if (bus.i_mem_ack) begin
                    state_nxt = ADDR;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. Includes a program_counter model,
// an instruction memory returning addr ^ 16'hA5A5 with configurable wait,
// and a stream reference: accepted words must be consecutive addresses
// starting at the PC reset value or at the latest flush target.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam logic [DW-1:0] PATTERN = 16'hA5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc;
    logic          pc_addr_en;
    logic          pc_lock;
    logic          pc_set_en;
    logic [AW-1:0] pc_set_address;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_addr = '0;

    int vectors     = 0;
    int miscompares = 0;
    int accepted    = 0;
    int mem_latency = 0;
    bit rand_latency = 1'b0;

    instr_fetch_if #(.AW(AW), .DW(DW)) bus();

    instr_fetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_pc_address     (pc),
        .o_pc_addr_en     (pc_addr_en),
        .o_pc_lock        (pc_lock),
        .o_pc_set_en      (pc_set_en),
        .o_pc_set_address (pc_set_address),
        .bus              (bus),
        .i_flush          (flush),
        .i_flush_addr     (flush_addr)
    );

    always #5 clk = ~clk;

    // program_counter model: set beats lock, otherwise advance when unlocked
    always @(posedge clk or negedge rst) begin
        if (!rst)            pc <= '0;
        else if (pc_set_en)  pc <= pc_set_address;
        else if (!pc_lock)   pc <= pc + 1'b1;
    end

    // instruction memory: answers each request after a wait, one-cycle ack
    initial begin : mem_model
        bit busy;
        int wait_left;
        busy = 1'b0;
        wait_left = 0;
        bus.i_mem_ack = 1'b0;
        bus.i_mem_data = '0;
        bus.i_instr_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 1'b0;
                bus.i_mem_ack = 1'b0;
            end else begin
                if (bus.i_mem_ack) begin
                    bus.i_mem_ack = 1'b0;
                    busy = 1'b0;
                end
                if (bus.o_mem_req) begin
                    if (!busy) begin
                        busy = 1'b1;
                        wait_left = rand_latency ? int'($urandom_range(0, 3)) : mem_latency;
                    end
                    if (wait_left == 0) begin
                        bus.i_mem_ack  = 1'b1;
                        bus.i_mem_data = bus.o_mem_addr ^ PATTERN;
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    // stream reference and handshake rules, sampled just before each edge
    initial begin : monitor
        logic          prev_req;
        logic          prev_ack;
        logic [AW-1:0] prev_addr;
        logic          flushed_outstanding;
        logic          exp_lock;
        logic [AW-1:0] exp_next;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        flushed_outstanding = 1'b0;
        exp_next = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                exp_next = '0;
                prev_req = 1'b0;
                prev_ack = 1'b0;
                flushed_outstanding = 1'b0;
            end else begin
                if (prev_req && !prev_ack) begin
                    vectors++;
                    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== prev_addr) begin
                        miscompares++;
                        $display("[TB] FAIL req_hold: req=%b addr=%h, expected req=1 addr=%h",
                                 bus.o_mem_req, bus.o_mem_addr, prev_addr);
                    end
                end
                exp_lock = !(bus.o_mem_req && bus.i_mem_ack && !flush && !flushed_outstanding);
                vectors++;
                if (pc_lock !== exp_lock) begin
                    miscompares++;
                    $display("[TB] FAIL pc_lock: got %b expected %b (req=%b ack=%b flush=%b)",
                             pc_lock, exp_lock, bus.o_mem_req, bus.i_mem_ack, flush);
                end
                vectors++;
                if (pc_set_en !== flush || (flush && pc_set_address !== flush_addr)) begin
                    miscompares++;
                    $display("[TB] FAIL pc_set: got en=%b addr=%h expected en=%b addr=%h",
                             pc_set_en, pc_set_address, flush, flush_addr);
                end
                if (bus.o_instr_valid && bus.i_instr_ready) begin
                    vectors++;
                    if (flush || bus.o_instr_addr !== exp_next || bus.o_instr !== (exp_next ^ PATTERN)) begin
                        miscompares++;
                        $display("[TB] FAIL stream: got addr=%h word=%h flush=%b expected addr=%h word=%h",
                                 bus.o_instr_addr, bus.o_instr, flush, exp_next, exp_next ^ PATTERN);
                    end
                    exp_next = exp_next + 1'b1;
                    accepted++;
                end
                if (flush) exp_next = flush_addr;
                if (bus.o_mem_req && bus.i_mem_ack)   flushed_outstanding = 1'b0;
                else if (bus.o_mem_req && flush)      flushed_outstanding = 1'b1;
                prev_req  = bus.o_mem_req;
                prev_ack  = bus.i_mem_ack;
                prev_addr = bus.o_mem_addr;
            end
        end
    end

    // wall-clock guard so the bench can never hang
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_req(input logic [AW-1:0] addr, input bit need_ack, output bit found);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            #2;
            if (bus.o_mem_req && bus.o_mem_addr == addr && (!need_ack || bus.i_mem_ack))
                found = 1'b1;
        end
    endtask

    task automatic wait_accept(output logic [AW-1:0] a, output logic [DW-1:0] d, output bit found);
        found = 1'b0;
        a = '0;
        d = '0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            #2;
            if (bus.o_instr_valid && bus.i_instr_ready) begin
                a = bus.o_instr_addr;
                d = bus.o_instr;
                found = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        flush = 1'b0;
        mem_latency = 0;
        rand_latency = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        #2;
        vectors++;
        if ({bus.o_mem_req, pc_lock, pc_addr_en, pc_set_en, bus.o_instr_valid} !== 5'b01000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got req/lock/aen/set/valid=%b expected 01000",
                     {bus.o_mem_req, pc_lock, pc_addr_en, pc_set_en, bus.o_instr_valid});
        end
        vectors++;
        if ({bus.o_instr, bus.o_instr_addr, bus.o_mem_addr, pc_set_address} !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got instr=%h iaddr=%h maddr=%h setaddr=%h expected all 0",
                     bus.o_instr, bus.o_instr_addr, bus.o_mem_addr, pc_set_address);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        int acks, unlocks, got, first_valid, cyc;
        bus.i_instr_ready = 1'b1;
        mem_latency = 0;
        do_reset();
        acks = 0; unlocks = 0; got = 0; first_valid = -1; cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            #2;
            cyc++;
            if (bus.o_instr_valid && first_valid < 0) first_valid = cyc;
            if (!pc_lock) unlocks++;
            if (bus.o_instr_valid && bus.i_instr_ready) begin
                vectors++;
                if (bus.o_instr_addr !== 16'(got) || bus.o_instr !== (16'(got) ^ PATTERN)) begin
                    miscompares++;
                    $display("[TB] FAIL stream_order: got addr=%h word=%h expected addr=%h",
                             bus.o_instr_addr, bus.o_instr, 16'(got));
                end
                got++;
            end
            if (bus.o_mem_req && bus.i_mem_ack) acks++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (acks != 4 || pc !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL stream_pc: got acks=%0d pc=%h expected acks=4 pc=0004", acks, pc);
        end
        vectors++;
        if (unlocks != 4) begin
            miscompares++;
            $display("[TB] FAIL stream_unlock: got %0d unlocked cycles expected 4", unlocks);
        end
        vectors++;
        if (first_valid != 3) begin
            miscompares++;
            $display("[TB] FAIL stream_latency: first valid at cycle %0d expected 3", first_valid);
        end
    endtask

    task automatic test_full_stall();
        int acks, cyc, reqs;
        logic [AW-1:0] req_seen;
        bus.i_instr_ready = 1'b0;
        mem_latency = 0;
        do_reset();
        acks = 0; cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            #2;
            cyc++;
            if (bus.o_mem_req && bus.i_mem_ack) acks++;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #2;
            vectors++;
            if (bus.o_mem_req !== 1'b0 || pc !== 16'd4 || bus.o_instr_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stall_hold: got req=%b pc=%h valid=%b expected req=0 pc=0004 valid=1",
                         bus.o_mem_req, pc, bus.o_instr_valid);
            end
        end
        @(negedge clk);
        bus.i_instr_ready = 1'b1;
        @(negedge clk);
        bus.i_instr_ready = 1'b0;
        reqs = 0;
        req_seen = '0;
        for (int c = 0; c < 12; c++) begin
            #2;
            if (bus.o_mem_req && bus.i_mem_ack) begin
                reqs++;
                req_seen = bus.o_mem_addr;
            end
            @(negedge clk);
        end
        #2;
        vectors++;
        if (reqs != 1 || req_seen !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL stall_refill: got %0d requests last addr=%h expected 1 request addr=0004",
                     reqs, req_seen);
        end
        vectors++;
        if (bus.o_instr_addr !== 16'd1 || pc !== 16'd5) begin
            miscompares++;
            $display("[TB] FAIL stall_head: got head=%h pc=%h expected head=0001 pc=0005",
                     bus.o_instr_addr, pc);
        end
    endtask

    task automatic test_flush_in_req();
        bit found, drained;
        int cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.i_instr_ready = 1'b0;
        mem_latency = 3;
        do_reset();
        wait_req(16'd1, 1'b0, found);
        flush_addr = 16'h0100;
        flush = 1'b1;
        #1;
        vectors++;
        if (!found || pc_set_en !== 1'b1 || pc_set_address !== 16'h0100 || bus.o_instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_cycle: found=%b set_en=%b set_addr=%h valid=%b expected 1/1/0100/0",
                     found, pc_set_en, pc_set_address, bus.o_instr_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        drained = 1'b0;
        cyc = 0;
        while (!drained && cyc < 20) begin
            #2;
            cyc++;
            vectors++;
            if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 16'd1 || pc_set_en !== 1'b0 ||
                pc_lock !== 1'b1 || bus.o_instr_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL drain_hold: got req=%b addr=%h set=%b lock=%b valid=%b expected 1/0001/0/1/0",
                         bus.o_mem_req, bus.o_mem_addr, pc_set_en, pc_lock, bus.o_instr_valid);
            end
            if (bus.i_mem_ack) drained = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (!drained || cyc != 3 || pc !== 16'h0100) begin
            miscompares++;
            $display("[TB] FAIL drain_end: drained=%b cycles=%0d pc=%h expected 1/3/0100", drained, cyc, pc);
        end
        bus.i_instr_ready = 1'b1;
        mem_latency = 0;
        wait_accept(a, d, found);
        vectors++;
        if (!found || a !== 16'h0100 || d !== (16'h0100 ^ PATTERN)) begin
            miscompares++;
            $display("[TB] FAIL flush_target: got found=%b addr=%h word=%h expected addr=0100 word=%h",
                     found, a, d, 16'h0100 ^ PATTERN);
        end
    endtask

    task automatic test_flush_with_ack();
        bit found;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.i_instr_ready = 1'b1;
        mem_latency = 0;
        do_reset();
        wait_req(16'd2, 1'b1, found);
        flush_addr = 16'h0200;
        flush = 1'b1;
        #1;
        vectors++;
        if (!found || pc_lock !== 1'b1 || pc_set_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_ack_cycle: found=%b lock=%b set_en=%b expected 1/1/1",
                     found, pc_lock, pc_set_en);
        end
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (pc !== 16'h0200) begin
            miscompares++;
            $display("[TB] FAIL flush_ack_pc: got pc=%h expected 0200", pc);
        end
        wait_accept(a, d, found);
        vectors++;
        if (!found || a !== 16'h0200 || d !== (16'h0200 ^ PATTERN)) begin
            miscompares++;
            $display("[TB] FAIL flush_ack_next: got found=%b addr=%h word=%h expected addr=0200",
                     found, a, d);
        end
    endtask

    task automatic test_wrap();
        bit found0, found1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        bus.i_instr_ready = 1'b1;
        mem_latency = 0;
        do_reset();
        @(negedge clk);
        flush_addr = 16'hFFFF;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_accept(a0, d0, found0);
        wait_accept(a1, d1, found1);
        vectors++;
        if (!found0 || !found1 || a0 !== 16'hFFFF || a1 !== 16'h0000 ||
            d0 !== (16'hFFFF ^ PATTERN) || d1 !== PATTERN) begin
            miscompares++;
            $display("[TB] FAIL wrap: got %h/%h words %h/%h expected FFFF/0000 words %h/%h",
                     a0, a1, d0, d1, 16'hFFFF ^ PATTERN, PATTERN);
        end
    endtask

    task automatic test_reset_mid_req();
        bit found;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.i_instr_ready = 1'b1;
        mem_latency = 3;
        do_reset();
        wait_req(16'd1, 1'b0, found);
        rst = 1'b0;
        #1;
        vectors++;
        if (!found || bus.o_mem_req !== 1'b0 || bus.o_instr_valid !== 1'b0 || pc_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_req: found=%b req=%b valid=%b lock=%b expected 1/0/0/1",
                     found, bus.o_mem_req, bus.o_instr_valid, pc_lock);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_latency = 0;
        wait_accept(a, d, found);
        vectors++;
        if (!found || a !== 16'h0000 || d !== PATTERN) begin
            miscompares++;
            $display("[TB] FAIL reset_restart: got found=%b addr=%h word=%h expected addr=0000 word=%h",
                     found, a, d, PATTERN);
        end
    endtask

    task automatic test_random();
        int start;
        rand_latency = 1'b1;
        bus.i_instr_ready = 1'b1;
        do_reset();
        start = accepted;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.i_instr_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            if (flush) begin
                if ($urandom_range(0, 2) == 0) flush_addr = 16'hFFFC + 16'($urandom_range(0, 3));
                else                           flush_addr = 16'($urandom);
            end
        end
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        rand_latency = 1'b0;
        vectors++;
        if (accepted - start < 50) begin
            miscompares++;
            $display("[TB] FAIL random_progress: got %0d words accepted expected at least 50",
                     accepted - start);
        end
    endtask

    initial begin : main
        test_reset();
        test_stream();
        test_full_stall();
        test_flush_in_req();
        test_flush_with_ack();
        test_wrap();
        test_reset_mid_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of program_counter.
- Gates the PC through its lock, address-enable and set controls, and reads 16-bit instruction words from instruction memory over a req/ack handshake.
- Buffers fetched words with their addresses in a small FIFO.
- Presents words to the decoder over valid/ready. A decoder-issued flush redirects the PC.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, >=2)
- AW, 16, address width (matches PC)
- DW, 16, instruction word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- i_pc_address  in  AW  PC o_address (valid only while o_pc_addr_en=1)
- o_pc_addr_en  out  1  to PC i_address_en
- o_pc_lock  out  1  to PC i_lock
- o_pc_set_en  out  1  to PC i_set_en
- o_pc_set_address  out  AW  to PC i_set_address
- o_mem_req  out  1  memory read request, held until ack
- o_mem_addr  out  AW  memory read address
- i_mem_ack  in  1  one-cycle ack; data valid the same cycle
- i_mem_data  in  DW  memory read data
- o_instr_valid  out  1  instruction available
- o_instr  out  DW  FIFO head word
- o_instr_addr  out  AW  FIFO head address
- i_instr_ready  in  1  decoder accepts the head word
- i_flush  in  1  redirect request, one cycle
- i_flush_addr  in  AW  redirect target

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; FIFO empty (count=0); req_addr=0.
  - Outputs: o_mem_req=0, o_pc_lock=1, o_pc_addr_en=0, o_pc_set_en=0, o_instr_valid=0.
  - o_instr, o_instr_addr, o_mem_addr, o_pc_set_address = 0.
- FSM states: IDLE, ADDR, REQ, DRAIN.
- IDLE:
  - Requests nothing.
  - Goes to ADDR next edge when count<DEPTH (after any pop this cycle) and i_flush=0.
- ADDR:
  - o_pc_addr_en=1; req_addr<=i_pc_address.
  - Goes to REQ next edge.
- REQ:
  - o_mem_req=1; o_mem_addr=req_addr.
  - On i_mem_ack: push {req_addr,i_mem_data}; o_pc_lock=0 in that cycle only, so the PC advances by exactly 1.
  - Next state is ADDR if post-push count<DEPTH, else IDLE.
- o_pc_lock=1 in every cycle except the REQ ack cycle. Exactly one PC increment per accepted word.
- Only one outstanding request at a time. ADDR is entered only when a slot is free, so a push never hits a full FIFO.
- Throughput: one word per 2 cycles with zero-wait memory. Latency from a free slot to o_instr_valid is 3 cycles minimum (IDLE, ADDR, REQ+ack, then valid).
- FIFO output:
  - o_instr_valid = (count!=0) && !i_flush.
  - Pop on valid&&ready.
  - Push and pop in the same cycle leave count unchanged.
  - Head is ordered by issue.
  - Pointers wrap modulo DEPTH.
- Flush (any state):
  - o_pc_set_en=1 and o_pc_set_address=i_flush_addr combinationally in the same cycle. The PC loads the target at the next edge; set has priority over lock in the PC.
  - FIFO cleared at that edge. A pop in the flush cycle is ignored.
  - From IDLE or ADDR: go to ADDR (the capture uses the new PC the cycle after).
  - From REQ without ack: go to DRAIN and keep o_mem_req/o_mem_addr asserted until ack, then discard the data and go to ADDR. The PC is not unlocked.
  - From REQ with ack in the same cycle: data discarded, no push, PC not unlocked, go to ADDR.
  - Flush during DRAIN: PC redirected again, FIFO stays empty, remain in DRAIN.
- Memory ack outside REQ/DRAIN is ignored.
- Reset mid-request drops o_mem_req immediately. Memory must tolerate an abandoned request.
- All address arithmetic wraps at 2^AW (the PC wraps 16'hFFFF->0).

Decomposition:
- Shared header fetch_defs.vh holds:
  - state encodings (IDLE=2'd0, ADDR=2'd1, REQ=2'd2, DRAIN=2'd3)
  - default AW/DW widths, shared with program_counter users
- One sub-module, fetch_buffer: synchronous FIFO of {AW+DW} entries with push, pop, clear, count, async active-low reset.
- The FSM and PC/memory control stay in instr_fetch.

Test Plan:
- Reset release, PC=0, memory returns word=addr^16'hA5A5 with zero wait, ready=1 -> words for addresses 0,1,2,3 appear in order; o_pc_lock low exactly one cycle per word; PC=4 after the 4th ack.
- ready=0 with DEPTH=4 -> after 4 acks FSM stays IDLE, o_mem_req=0, PC frozen at 4. Raise ready for 1 cycle -> exactly one new request for address 4.
- Flush to 16'h0100 while in REQ with ack delayed 3 cycles -> o_pc_set_en high 1 cycle; DRAIN holds req until ack; data discarded; next o_instr_addr=16'h0100; o_instr_valid=0 in the flush cycle.
- Flush asserted in the same cycle as ack -> no push, PC loaded with the target (not incremented), next fetch from the target.
- PC preset to 16'hFFFF via flush -> fetched addresses FFFF then 0000.
- Assert rst mid-REQ -> o_mem_req=0 and o_instr_valid=0 immediately; after release, fetch restarts from PC reset value 0.
